// File: rtl/panel_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// panel_pkg : shared types and clock constants for the front-panel blocks.
// Rev 1.0
// ----------------------------------------------------------------------------
package panel_pkg;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } ctrl_state_t;

  localparam int CLK_HZ           = 50000000;
  localparam int TICK_HZ          = 1000;
  localparam int TICK_DIV_DEFAULT = CLK_HZ / TICK_HZ;

endpackage
`default_nettype wire

// File: rtl/panel_clock_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// panel_clock_ctrl_if : panel-side and CPU-side signals of the clock controller.
// Rev 1.0
// ----------------------------------------------------------------------------
interface panel_clock_ctrl_if;

  logic tick;
  logic step_rise;
  logic run_rise;
  logic fast;
  logic halt_in;
  logic cpu_clken;
  logic running;
  logic halted;

  // slave is the controller itself; master is the panel/CPU environment
  modport slave (
    input  step_rise, run_rise, fast, halt_in,
    output tick, cpu_clken, running, halted
  );

  modport master (
    output step_rise, run_rise, fast, halt_in,
    input  tick, cpu_clken, running, halted
  );

endinterface
`default_nettype wire

// File: rtl/panel_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// panel_tick_gen : free-running one-clock tick every TICK_DIV system clocks.
// Rev 1.0
// ----------------------------------------------------------------------------
module panel_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_tcnt_last = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] c_tcnt_one  = CW'(1);

  logic [CW-1:0] tcnt_q, tcnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tcnt_d = tcnt_q + c_tcnt_one;
    tick_d = 1'b0;
    if (tcnt_q == c_tcnt_last) begin
      tcnt_d = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/panel_clock_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// panel_clock_ctrl : sequences the SAP CPU clock enable from panel STEP/RUN
// buttons (single-step, slow run, fast run, halted) and supplies the 1 ms tick.
// Rev 1.0
// ----------------------------------------------------------------------------
module panel_clock_ctrl
  import panel_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int RUN_TICKS = 250
) (
  input  logic               clock,
  input  logic               reset,
  panel_clock_ctrl_if.slave  bus
);

  localparam int RW = $clog2(RUN_TICKS) + 1;
  localparam logic [RW-1:0] c_rate_last = RW'(RUN_TICKS - 1);
  localparam logic [RW-1:0] c_rate_one  = RW'(1);

  logic tick_w;

  panel_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tick_w)
  );

  ctrl_state_t   state_q, state_d;
  logic [RW-1:0] rate_q, rate_d;
  logic          cpu_clken_q, cpu_clken_d;
  logic          running_q, running_d;
  logic          halted_q, halted_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_STOP;
      rate_q      <= '0;
      cpu_clken_q <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      cpu_clken_q <= cpu_clken_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
    end
  end

  // cpu_clken_d is the enable for the cycle after this edge, hence registered
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    cpu_clken_d = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (bus.halt_in) begin
          state_d = ST_HALTED;
        end else if (bus.run_rise) begin
          state_d = ST_RUN;
          rate_d  = '0;
        end else if (bus.step_rise) begin
          state_d     = ST_STEP;
          cpu_clken_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = bus.halt_in ? ST_HALTED : ST_STOP;
      end
      ST_RUN: begin
        if (bus.halt_in) begin
          state_d = ST_HALTED;
        end else if (bus.run_rise) begin
          state_d = ST_STOP;
        end else if (bus.fast) begin
          cpu_clken_d = 1'b1;
        end else if (tick_w) begin
          if (rate_q == c_rate_last) begin
            rate_d      = '0;
            cpu_clken_d = 1'b1;
          end else begin
            rate_d = rate_q + c_rate_one;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALTED);
  end

  assign bus.tick      = tick_w;
  assign bus.cpu_clken = cpu_clken_q;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_panel_clock_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_panel_clock_ctrl : randomized and directed checks against a cycle model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_panel_clock_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int RUN_TICKS = 3;
  localparam int M_STOP = 0, M_STEP = 1, M_RUN = 2, M_HALT = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  panel_clock_ctrl_if bus();

  panel_clock_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .RUN_TICKS (RUN_TICKS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, clocks since reset release, slow ticks since RUN entry
  int   m_mode = M_STOP;
  int   m_cyc  = 0;
  int   m_slow = 0;
  logic e_tick  = 1'b0;
  logic e_clken = 1'b0;

  function automatic logic [3:0] exp_vec();
    return {e_tick, e_clken, (m_mode == M_RUN), (m_mode == M_HALT)};
  endfunction

  function automatic logic [3:0] obs_vec();
    return {bus.tick, bus.cpu_clken, bus.running, bus.halted};
  endfunction

  // Update model from inputs visible before the edge, then step past the edge
  task automatic advance();
    logic t_prev;
    t_prev = e_tick;
    if (reset) begin
      m_mode = M_STOP; m_cyc = 0; m_slow = 0; e_tick = 1'b0; e_clken = 1'b0;
    end else begin
      m_cyc++;
      e_clken = 1'b0;
      case (m_mode)
        M_STOP: begin
          if (bus.halt_in) m_mode = M_HALT;
          else if (bus.run_rise) begin m_mode = M_RUN; m_slow = 0; end
          else if (bus.step_rise) begin m_mode = M_STEP; e_clken = 1'b1; end
        end
        M_STEP: m_mode = bus.halt_in ? M_HALT : M_STOP;
        M_RUN: begin
          if (bus.halt_in) m_mode = M_HALT;
          else if (bus.run_rise) m_mode = M_STOP;
          else if (bus.fast) e_clken = 1'b1;
          else if (t_prev) begin
            m_slow++;
            e_clken = ((m_slow % RUN_TICKS) == 0);
          end
        end
        default: ;
      endcase
      e_tick = ((m_cyc % TICK_DIV) == 0);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.step_rise = 1'b0; bus.run_rise = 1'b0; bus.fast = 1'b0; bus.halt_in = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (obs_vec() !== 4'b0000) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b exp=0000", i, obs_vec());
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_tick();
    for (int i = 1; i <= 20; i++) begin
      advance();
      checks++;
      if (obs_vec() !== {((i % TICK_DIV) == 0), 3'b000}) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b exp=%b", i, obs_vec(), {((i % TICK_DIV) == 0), 3'b000});
      end
    end
  endtask

  task automatic test_step();
    int pulses;
    for (int rep = 0; rep < 2; rep++) begin
      pulses = 0;
      bus.step_rise = 1'b1;
      advance();
      bus.step_rise = 1'b0;
      checks++;
      if (bus.cpu_clken !== 1'b1) begin
        errors++;
        $display("FAIL step_latency rep=%0d got=%b exp=1", rep, bus.cpu_clken);
      end
      pulses += int'(bus.cpu_clken);
      for (int i = 0; i < 10; i++) begin
        advance();
        pulses += int'(bus.cpu_clken);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL step cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
        end
      end
      checks++;
      if (pulses != 1) begin
        errors++;
        $display("FAIL step_count rep=%0d got=%0d exp=1", rep, pulses);
      end
    end
  endtask

  task automatic test_slow_run();
    int pulse_cyc[$];
    do_reset();
    bus.run_rise = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      advance();
      bus.run_rise = 1'b0;
      if (bus.cpu_clken === 1'b1) pulse_cyc.push_back(i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL slow_run cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    // 3rd tick shows in cycle 12, so pulses land in 13, 25, 37
    checks++;
    if (pulse_cyc.size() != 3 || pulse_cyc[0] != 13 || pulse_cyc[1] != 25 || pulse_cyc[2] != 37) begin
      errors++;
      $display("FAIL slow_pulse_times got=%p exp=13,25,37", pulse_cyc);
    end
    bus.run_rise = 1'b1;
    advance();
    bus.run_rise = 1'b0;
    for (int i = 0; i < 30; i++) begin
      advance();
      checks++;
      if (bus.cpu_clken !== 1'b0 || bus.running !== 1'b0) begin
        errors++;
        $display("FAIL run_stop cyc=%0d got clken=%b running=%b exp 0,0", i, bus.cpu_clken, bus.running);
      end
    end
  endtask

  task automatic test_fast_halt();
    do_reset();
    bus.run_rise = 1'b1;
    advance();
    bus.run_rise = 1'b0;
    for (int i = 0; i < 6; i++) advance();
    bus.fast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      advance();
      checks++;
      if (bus.cpu_clken !== 1'b1 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fast cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    bus.fast = 1'b0;
    for (int i = 0; i < 30; i++) begin
      advance();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fast_resume cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    bus.halt_in = 1'b1;
    advance();
    bus.halt_in = 1'b0;
    checks++;
    if (bus.halted !== 1'b1 || bus.cpu_clken !== 1'b0 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL halt got halted=%b clken=%b running=%b exp 1,0,0", bus.halted, bus.cpu_clken, bus.running);
    end
    for (int i = 0; i < 20; i++) begin
      bus.run_rise  = ($urandom % 3) == 0;
      bus.step_rise = ($urandom % 3) == 0;
      bus.fast      = $urandom % 2;
      advance();
      checks++;
      if (bus.halted !== 1'b1 || bus.cpu_clken !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL halted_sticky cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.run_rise = 1'b1; bus.step_rise = 1'b1;
    advance();
    clear_inputs();
    checks++;
    if (bus.running !== 1'b1 || bus.cpu_clken !== 1'b0) begin
      errors++;
      $display("FAIL run_beats_step got running=%b clken=%b exp 1,0", bus.running, bus.cpu_clken);
    end
    do_reset();
    bus.step_rise = 1'b1; bus.halt_in = 1'b1;
    advance();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.halted !== 1'b1 || bus.cpu_clken !== 1'b0) begin
        errors++;
        $display("FAIL halt_beats_step cyc=%0d got halted=%b clken=%b exp 1,0", i, bus.halted, bus.cpu_clken);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bus.run_rise = 1'b1;
    advance();
    bus.run_rise = 1'b0;
    bus.fast = 1'b1;
    for (int i = 0; i < 6; i++) advance();
    reset = 1'b1;
    advance();
    checks++;
    if (obs_vec() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_run got=%b exp=0000", obs_vec());
    end
    reset = 1'b0;
    bus.fast = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      advance();
      checks++;
      if (bus.tick !== ((i % TICK_DIV) == 0) || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_tick_phase cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        bus.step_rise = ($urandom % 8) == 0;
        bus.run_rise  = ($urandom % 20) == 0;
        if (($urandom % 24) == 0) bus.fast = ~bus.fast;
        bus.halt_in   = ($urandom % 400) == 0;
        advance();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random r=%0d cyc=%0d got=%b exp=%b", round, i, obs_vec(), exp_vec());
        end
      end
      clear_inputs();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_tick();
    test_step();
    test_slow_run();
    test_fast_halt();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
